// File: rtl/rgb_pwm_driver.sv
// Double-buffered, brightness-scaled 3-channel PWM driver for RGB LEDs.
// Optional build macro: RGB_PWM_PHASE_STAGGER_EN spreads channel phases by 85/170 counts.
module rgb_pwm_driver #(
    parameter int          PRESCALE   = 1,
    parameter logic [7:0]  RESET_DUTY = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic [7:0] brightness,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic       period_tick
);

    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_LOADED = 1'b1;

    // (duty * (brightness+1)) >> 8; brightness 255 is identity, 0 forces off
    function automatic logic [7:0] scale_duty(input logic [7:0] duty, input logic [7:0] bright);
        logic [15:0] prod;
        prod = {8'd0, duty} * ({8'd0, bright} + 16'd1);
        return prod[15:8];
    endfunction

    logic [PS_W-1:0] prescaler_r;
    logic [7:0]      pwm_cnt_r;
    logic [0:0]      state_r;
    logic [7:0]      shadow_r_r, shadow_g_r, shadow_b_r;
    logic [7:0]      active_r_r, active_g_r, active_b_r;
    logic            rgb_r_r, rgb_g_r, rgb_b_r;
    logic            period_tick_r;

    logic            step_s;
    logic            wrap_s;
    logic            accept_s;
    logic [7:0]      cnt_r_s, cnt_g_s, cnt_b_s;

    assign step_s   = (prescaler_r == PS_MAX);
    assign wrap_s   = step_s && (pwm_cnt_r == 8'd255);
    assign in_ready = (state_r == ST_EMPTY);
    assign accept_s = in_valid && in_ready;

    // Per-channel compare counters; stagger only shifts phase, never duty ratio
    always_comb begin
        cnt_r_s = pwm_cnt_r;
`ifdef RGB_PWM_PHASE_STAGGER_EN
        cnt_g_s = pwm_cnt_r + 8'd85;
        cnt_b_s = pwm_cnt_r + 8'd170;
`else
        cnt_g_s = pwm_cnt_r;
        cnt_b_s = pwm_cnt_r;
`endif
    end

    // Prescaler and free-running PWM period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_r <= {PS_W{1'b0}};
            pwm_cnt_r   <= 8'd0;
        end else if (step_s) begin
            prescaler_r <= {PS_W{1'b0}};
            pwm_cnt_r   <= pwm_cnt_r + 8'd1;
        end else begin
            prescaler_r <= prescaler_r + {{(PS_W-1){1'b0}}, 1'b1};
            pwm_cnt_r   <= pwm_cnt_r;
        end
    end

    // Pending-flag FSM; a wrap always drains LOADED, an accept always fills EMPTY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY:  state_r <= accept_s ? ST_LOADED : ST_EMPTY;
                ST_LOADED: state_r <= wrap_s   ? ST_EMPTY  : ST_LOADED;
                default:   state_r <= ST_EMPTY;
            endcase
        end
    end

    // Shadow capture on handshake; shadow persists so each wrap can rescale it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r_r <= RESET_DUTY;
            shadow_g_r <= RESET_DUTY;
            shadow_b_r <= RESET_DUTY;
        end else if (accept_s) begin
            shadow_r_r <= in_r;
            shadow_g_r <= in_g;
            shadow_b_r <= in_b;
        end else begin
            shadow_r_r <= shadow_r_r;
            shadow_g_r <= shadow_g_r;
            shadow_b_r <= shadow_b_r;
        end
    end

    // Active duties only change at the period boundary, from the pre-edge shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r_r <= RESET_DUTY;
            active_g_r <= RESET_DUTY;
            active_b_r <= RESET_DUTY;
        end else if (wrap_s) begin
            active_r_r <= scale_duty(shadow_r_r, brightness);
            active_g_r <= scale_duty(shadow_g_r, brightness);
            active_b_r <= scale_duty(shadow_b_r, brightness);
        end else begin
            active_r_r <= active_r_r;
            active_g_r <= active_g_r;
            active_b_r <= active_b_r;
        end
    end

    // Registered pin compare and period pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r_r       <= 1'b0;
            rgb_g_r       <= 1'b0;
            rgb_b_r       <= 1'b0;
            period_tick_r <= 1'b0;
        end else begin
            rgb_r_r       <= (cnt_r_s < active_r_r);
            rgb_g_r       <= (cnt_g_s < active_g_r);
            rgb_b_r       <= (cnt_b_s < active_b_r);
            period_tick_r <= wrap_s;
        end
    end

    assign RGB_R       = rgb_r_r;
    assign RGB_G       = rgb_g_r;
    assign RGB_B       = rgb_b_r;
    assign period_tick = period_tick_r;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: an arithmetic reference model queues the
// expected per-cycle outputs, a monitor pops and compares after every clock edge.
module tb_rgb_pwm_driver;

    localparam int         PRESCALE   = 1;
    localparam logic [7:0] RESET_DUTY = 8'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;
    logic [7:0] brightness = 8'd255;
    logic       RGB_R, RGB_G, RGB_B, period_tick;

    rgb_pwm_driver #(.PRESCALE(PRESCALE), .RESET_DUTY(RESET_DUTY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .brightness(brightness),
        .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expected {in_ready, R, G, B, period_tick} after each active edge
    logic [4:0] exp_q[$];

    // reference model: time index since reset plus duty arrays
    int m_n;
    int m_shadow[3];
    int m_active[3];
    bit m_pending;
    bit m_last_accept;
    int m_offset[3];

    task automatic model_reset();
        m_n = 0;
        m_pending = 1'b0;
        m_last_accept = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_shadow[c] = int'(RESET_DUTY);
            m_active[c] = int'(RESET_DUTY);
        end
`ifdef RGB_PWM_PHASE_STAGGER_EN
        m_offset[0] = 0; m_offset[1] = 85; m_offset[2] = 170;
`else
        m_offset[0] = 0; m_offset[1] = 0;  m_offset[2] = 0;
`endif
    endtask

    // advance the model by one clock using the inputs that will be sampled
    task automatic model_step();
        int  cnt;
        bit  wrap;
        bit  hi[3];
        int  in_v[3];
        cnt  = (m_n / PRESCALE) % 256;
        wrap = ((m_n % PRESCALE) == PRESCALE - 1) && (cnt == 255);
        for (int c = 0; c < 3; c++) hi[c] = (((cnt + m_offset[c]) % 256) < m_active[c]);
        in_v[0] = int'(in_r); in_v[1] = int'(in_g); in_v[2] = int'(in_b);
        m_last_accept = in_valid && !m_pending;
        if (wrap) begin
            for (int c = 0; c < 3; c++) m_active[c] = (m_shadow[c] * (int'(brightness) + 1)) / 256;
            m_pending = 1'b0;
        end
        if (m_last_accept) begin
            for (int c = 0; c < 3; c++) m_shadow[c] = in_v[c];
            m_pending = 1'b1;
        end
        exp_q.push_back({!m_pending, hi[0], hi[1], hi[2], wrap});
        m_n++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_with(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        in_valid = v; in_r = r; in_g = g; in_b = b;
        if (rst_n) model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_with(1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int waited;
        waited = 0;
        do begin
            step_with(1'b1, r, g, b);
            waited++;
        end while (!m_last_accept && waited < 2000);
        if (!m_last_accept) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 2000 clks");
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        in_valid = 1'b0;
        model_reset();
        rst_n = 1'b1;
        model_step();
    endtask

    function automatic logic [7:0] pick_duty();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 0)      return 8'd0;
        else if (sel == 1) return 8'd255;
        else               return 8'($urandom_range(0, 255));
    endfunction

    // monitor: every active edge out of reset must match the head of the queue
    initial begin
        logic [4:0] got;
        logic [4:0] exp;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) begin
                #1;
                got = {in_ready, RGB_R, RGB_G, RGB_B, period_tick};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: got %b expected a queued entry", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL outputs t=%0t rdy/r/g/b/tick: got %b expected %b", $time, got, exp);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);

        // idle periods: tick every 256 clks, all outputs low
        brightness = 8'd255;
        release_reset();
        idle(600);

        // full brightness passes duty through unchanged
        send(8'd128, 8'd0, 8'd255);
        idle(600);

        // half-ish brightness: 200/64/1 -> 100/32/0
        brightness = 8'd127;
        send(8'd200, 8'd64, 8'd1);
        idle(520);

        // back-to-back triplets: second stalls until the first one's wrap
        brightness = 8'd255;
        send(8'd10, 8'd10, 8'd10);
        send(8'd250, 8'd250, 8'd250);
        idle(800);

        // brightness 0 forces everything off at the next wrap
        brightness = 8'd0;
        idle(520);
        brightness = 8'd255;
        idle(300);

        // pending triplet discarded by reset at cnt 100
        send(8'd200, 8'd150, 8'd100);
        while ((m_n % 256) != 100) idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'd0);
        chk("async_reset_tick", 32'(period_tick), 32'd0);
        chk("async_reset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        release_reset();
        idle(600);

`ifdef RGB_PWM_PHASE_STAGGER_EN
        send(8'd85, 8'd85, 8'd85);
        idle(600);
`endif

        // randomized traffic, including valid pulses that ignore in_ready
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) brightness = 8'd255;
            else if ($urandom_range(0, 5) == 0) brightness = 8'd0;
            else brightness = 8'($urandom_range(0, 255));
            send(pick_duty(), pick_duty(), pick_duty());
            for (int j = 0; j < int'($urandom_range(0, 400)); j++)
                step_with($urandom_range(0, 7) == 0, pick_duty(), pick_duty(), pick_duty());
        end
        idle(300);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
